// File: rtl/phoneme_playback_ctrl.sv
// Phoneme playback controller.
// On start, the controller looks up the start and end flash word addresses of the
// selected phoneme. It then fetches one 32-bit word at a time and plays the four
// bytes of each word, low byte first, at the audio tick rate. When the phoneme
// ends it pulses done.
//
// Handshakes:
//   - A flash read request is accepted in a cycle where flash_read=1 and
//     flash_waitrequest=0.
//   - flash_read and flash_addr stay stable while the flash is stalled.
//   - Read data is taken only from a cycle where flash_readdatavalid=1.
//   - flash_readdatavalid is ignored outside WAIT_DATA.
module phoneme_playback_ctrl #(
    parameter int CLK_FREQ_IN_HZ = 25000000,
    parameter int SAMPLE_RATE_HZ = 22000,
    parameter int ADDR_W         = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            phoneme_select,
    output logic [7:0]            tbl_addr,
    input  logic [2*ADDR_W-1:0]   tbl_data,
    output logic                  flash_read,
    output logic [ADDR_W-1:0]     flash_addr,
    input  logic                  flash_waitrequest,
    input  logic [31:0]           flash_readdata,
    input  logic                  flash_readdatavalid,
    output logic [7:0]            audio_out,
    output logic                  audio_valid,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    localparam int DIV   = CLK_FREQ_IN_HZ / SAMPLE_RATE_HZ;
    localparam int CNT_W = $clog2(DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_LATCH,
        S_FETCH,
        S_WAIT_DATA,
        S_PLAY,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    div_q;
    logic                tick;
    logic [7:0]          tbl_addr_q, tbl_addr_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [31:0]         word_q, word_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [7:0]          audio_q, audio_d;
    logic                audio_valid_q, audio_valid_d;

    assign tick = (div_q == CNT_W'(DIV - 1));

    // Free-running audio-rate divider; only reset restarts it, start does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + CNT_W'(1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tbl_addr_q    <= '0;
            cur_q         <= '0;
            last_q        <= '0;
            word_q        <= '0;
            byte_idx_q    <= '0;
            audio_q       <= '0;
            audio_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tbl_addr_q    <= tbl_addr_d;
            cur_q         <= cur_d;
            last_q        <= last_d;
            word_q        <= word_d;
            byte_idx_q    <= byte_idx_d;
            audio_q       <= audio_d;
            audio_valid_q <= audio_valid_d;
        end
    end

    // Next-state logic: table lookup, one-word fetch, four-byte playback, done.
    always_comb begin
        state_d       = state_q;
        tbl_addr_d    = tbl_addr_q;
        cur_d         = cur_q;
        last_d        = last_q;
        word_d        = word_q;
        byte_idx_d    = byte_idx_q;
        audio_d       = audio_q;
        audio_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tbl_addr_d = phoneme_select;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                cur_d  = tbl_data[ADDR_W-1:0];
                last_d = tbl_data[2*ADDR_W-1:ADDR_W];
                // An end address below the start address marks an empty phoneme.
                if (tbl_data[2*ADDR_W-1:ADDR_W] < tbl_data[ADDR_W-1:0]) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!flash_waitrequest) begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (flash_readdatavalid) begin
                    word_d     = flash_readdata;
                    byte_idx_d = 2'd0;
                    state_d    = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    audio_d       = word_q[{byte_idx_q, 3'b000} +: 8];
                    audio_valid_d = 1'b1;
                    byte_idx_d    = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (cur_q == last_q) begin
                            state_d = S_DONE;
                        end else begin
                            cur_d   = cur_q + ADDR_W'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_DONE: begin
                audio_d = 8'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tbl_addr    = tbl_addr_q;
    assign flash_read  = (state_q == S_FETCH);
    assign flash_addr  = cur_q;
    assign audio_out   = audio_q;
    assign audio_valid = audio_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_phoneme_playback_ctrl.sv
// Testbench for phoneme_playback_ctrl: table-driven phonemes, directed corner cases
// and randomized phonemes checked against a list-based playback model.
module tb_phoneme_playback_ctrl;

  localparam int ADDR_W = 23;
  localparam int DIV    = 12;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [7:0]          phoneme_select;
  logic [7:0]          tbl_addr;
  logic [2*ADDR_W-1:0] tbl_data;
  logic                flash_read;
  logic [ADDR_W-1:0]   flash_addr;
  logic                flash_waitrequest = 1'b0;
  logic [31:0]         flash_readdata = '0;
  logic                flash_readdatavalid = 1'b0;
  logic [7:0]          audio_out;
  logic                audio_valid;
  logic                busy;
  logic                done;
  logic [2:0]          dbg_state;

  phoneme_playback_ctrl #(
    .CLK_FREQ_IN_HZ(DIV),
    .SAMPLE_RATE_HZ(1),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .phoneme_select(phoneme_select),
    .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .flash_read(flash_read),
    .flash_addr(flash_addr),
    .flash_waitrequest(flash_waitrequest),
    .flash_readdata(flash_readdata),
    .flash_readdatavalid(flash_readdatavalid),
    .audio_out(audio_out),
    .audio_valid(audio_valid),
    .busy(busy),
    .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- table ROM model (data one cycle after address) ----------------
  logic [2*ADDR_W-1:0] tbl_mem [256];
  always @(posedge clk) tbl_data <= tbl_mem[tbl_addr];

  // ---------------- flash model ----------------
  function automatic logic [31:0] flash_word(input logic [ADDR_W-1:0] a);
    if (a == 23'h10) return 32'h4433_2211;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A17_C3E9;
  endfunction

  int                stall_cfg = 0;
  int                lat_cfg = 0;
  int                stall_left = 0;
  bit                rdv_pend = 0;
  int                rdv_delay = 0;
  logic [31:0]       rdv_data = '0;
  bit                hold_chk = 0;
  logic [ADDR_W-1:0] hold_addr = '0;
  logic [ADDR_W-1:0] got_addr[$];

  // Drives the flash responses on the falling edge and logs accepted addresses.
  always @(negedge clk) begin
    if (hold_chk) begin
      check("addr_hold_during_stall", {flash_read, flash_addr}, {1'b1, hold_addr});
      hold_chk = 0;
    end
    flash_readdatavalid = 1'b0;
    flash_readdata      = $urandom;
    if (rdv_pend) begin
      if (rdv_delay == 0) begin
        flash_readdatavalid = 1'b1;
        flash_readdata      = rdv_data;
        rdv_pend            = 0;
      end else begin
        rdv_delay--;
      end
    end
    flash_waitrequest = 1'b0;
    if (flash_read) begin
      if (stall_left > 0) begin
        flash_waitrequest = 1'b1;
        stall_left--;
        hold_chk  = 1;
        hold_addr = flash_addr;
      end else begin
        got_addr.push_back(flash_addr);
        rdv_pend   = 1;
        rdv_delay  = lat_cfg;
        rdv_data   = flash_word(flash_addr);
        stall_left = stall_cfg;
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] got_s[$];
  int         got_t[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         busy_cnt = 0;
  int         first_read_cyc = -1;

  always @(negedge clk) begin
    if (audio_valid) begin
      got_s.push_back(audio_out);
      got_t.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (flash_read && first_read_cyc < 0) first_read_cyc = cyc;
  end

  // ---------------- scoreboard ----------------
  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] exp_addr[$];

  // Expected playback: every word from start to end inclusive, four bytes each, low byte first.
  task automatic build_model(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea);
    logic [31:0] w;
    exp_q.delete();
    exp_addr.delete();
    if (ea >= sa) begin
      for (longint a = longint'(sa); a <= longint'(ea); a++) begin
        exp_addr.push_back(ADDR_W'(a));
        w = flash_word(ADDR_W'(a));
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
      end
    end
  endtask

  task automatic clear_monitor();
    got_s.delete();
    got_t.delete();
    got_addr.delete();
    done_cnt       = 0;
    busy_cnt       = 0;
    first_read_cyc = -1;
  endtask

  // ---------------- driver: play one phoneme and score it ----------------
  task automatic run_phoneme(input string tag, input logic [7:0] sel,
                             input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                             input int stall, input int lat, input bit restart,
                             input int exp_reads, input int exp_samples);
    int  t0;
    int  budget;
    int  k;
    bit  restarted;
    tbl_mem[sel] = {ea, sa};
    build_model(sa, ea);
    step();
    clear_monitor();
    stall_cfg  = stall;
    stall_left = stall;
    lat_cfg    = lat;
    start          = 1'b1;
    phoneme_select = sel;
    t0 = cyc;
    step();
    start          = 1'b0;
    phoneme_select = 8'($urandom);
    budget    = 100 + (exp_reads + 1) * (4 * DIV + stall + lat + 20);
    k         = 0;
    restarted = 0;
    while (done_cnt == 0 && k < budget) begin
      start = 1'b0;
      if (restart && !restarted && got_s.size() >= 2) begin
        start          = 1'b1;
        phoneme_select = 8'd7;
        restarted      = 1;
      end
      step();
      k++;
    end
    start = 1'b0;
    check({tag, ":done_within_budget"}, 64'(done_cnt > 0), 64'd1);
    step();
    check({tag, ":busy_after_done"}, 64'(busy), 64'd0);
    check({tag, ":audio_zero_after_done"}, 64'(audio_out), 64'd0);
    repeat (4) step();
    check({tag, ":done_pulse_count"}, 64'(done_cnt), 64'd1);
    check({tag, ":busy_cycles"}, 64'(busy_cnt), 64'(done_cyc - t0));
    check({tag, ":read_count"}, 64'(got_addr.size()), 64'(exp_reads));
    check({tag, ":sample_count"}, 64'(got_s.size()), 64'(exp_samples));
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      check({tag, ":read_addr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
    for (int i = 0; i < got_s.size() && i < exp_q.size(); i++)
      check({tag, ":sample"}, 64'(got_s[i]), 64'(exp_q[i]));
    for (int i = 1; i < got_t.size(); i++)
      if (i % 4 != 0) check({tag, ":sample_spacing"}, 64'(got_t[i] - got_t[i-1]), 64'(DIV));
    if (exp_reads == 0) begin
      check({tag, ":no_flash_read"}, 64'(first_read_cyc), 64'(-1));
      check({tag, ":empty_done_latency"}, 64'(done_cyc - t0), 64'd3);
    end else begin
      check({tag, ":first_read_latency"}, 64'(first_read_cyc - t0), 64'd3);
    end
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    string             tag;
    logic [7:0]        sel;
    logic [ADDR_W-1:0] sa;
    logic [ADDR_W-1:0] ea;
    int                stall;
    int                lat;
    bit                restart;
    int                exp_reads;
    int                exp_samples;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k;
    vecs[0] = '{"T1_single_word", 8'd5,   23'h10,     23'h10,     0, 1, 1'b0, 1, 4};
    vecs[1] = '{"T2_multi_stall", 8'd9,   23'h20,     23'h22,     5, 2, 1'b0, 3, 12};
    vecs[2] = '{"T3_empty",       8'd3,   23'h30,     23'h2F,     0, 0, 1'b0, 0, 0};
    vecs[3] = '{"T4_start_busy",  8'd11,  23'h50,     23'h51,     1, 1, 1'b1, 2, 8};
    vecs[4] = '{"T6_all_ones",    8'd200, 23'h7FFFFF, 23'h7FFFFF, 0, 0, 1'b0, 1, 4};
    vecs[5] = '{"four_words",     8'd17,  23'h100,    23'h103,    2, 3, 1'b0, 4, 16};

    for (int i = 0; i < 256; i++) tbl_mem[i] = '0;
    // Entry 7 is the decoy for the start-while-busy case; it must never play.
    tbl_mem[7] = {23'h401, 23'h400};

    reset          = 1'b1;
    start          = 1'b0;
    phoneme_select = 8'd0;
    repeat (3) step();
    check("reset:tbl_addr", 64'(tbl_addr), 64'd0);
    check("reset:flash_read", 64'(flash_read), 64'd0);
    check("reset:flash_addr", 64'(flash_addr), 64'd0);
    check("reset:audio_out", 64'(audio_out), 64'd0);
    check("reset:audio_valid", 64'(audio_valid), 64'd0);
    check("reset:busy", 64'(busy), 64'd0);
    check("reset:done", 64'(done), 64'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++)
      run_phoneme(vecs[i].tag, vecs[i].sel, vecs[i].sa, vecs[i].ea, vecs[i].stall,
                  vecs[i].lat, vecs[i].restart, vecs[i].exp_reads, vecs[i].exp_samples);

    // T5: reset while waiting for flash data; the late readdatavalid must be dropped.
    tbl_mem[4] = {23'h41, 23'h40};
    step();
    clear_monitor();
    stall_cfg  = 0;
    stall_left = 0;
    lat_cfg    = 6;
    start          = 1'b1;
    phoneme_select = 8'd4;
    step();
    start = 1'b0;
    k = 0;
    while (got_addr.size() == 0 && k < 20) begin
      step();
      k++;
    end
    check("T5:read_accepted", 64'(got_addr.size()), 64'd1);
    step();
    reset = 1'b1;
    step();
    check("T5:tbl_addr", 64'(tbl_addr), 64'd0);
    check("T5:flash_read", 64'(flash_read), 64'd0);
    check("T5:flash_addr", 64'(flash_addr), 64'd0);
    check("T5:audio_out", 64'(audio_out), 64'd0);
    check("T5:audio_valid", 64'(audio_valid), 64'd0);
    check("T5:busy", 64'(busy), 64'd0);
    check("T5:done", 64'(done), 64'd0);
    reset = 1'b0;
    clear_monitor();
    repeat (20) step();
    check("T5:no_audio_after_reset", 64'(got_s.size()), 64'd0);
    check("T5:no_done_after_reset", 64'(done_cnt), 64'd0);
    check("T5:idle_after_reset", 64'(busy_cnt), 64'd0);
    check("T5:stale_data_delivered", 64'(rdv_pend), 64'd0);
    run_phoneme("T5_replay", 8'd5, 23'h10, 23'h10, 0, 1, 1'b0, 1, 4);

    // Randomized phonemes scored against the list model.
    for (int r = 0; r < 8; r++) begin
      logic [7:0]        sel;
      logic [ADDR_W-1:0] sa;
      logic [ADDR_W-1:0] ea;
      int                len;
      int                nwords;
      sel = 8'($urandom_range(20, 250));
      sa  = ADDR_W'($urandom_range(1, 23'h7FFF00));
      len = $urandom_range(0, 3);
      if (len == 0) begin
        ea     = sa - ADDR_W'(1);
        nwords = 0;
      end else begin
        ea     = sa + ADDR_W'(len - 1);
        nwords = len;
      end
      run_phoneme("random", sel, sa, ea, $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), nwords, 4 * nwords);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
